// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse encoder: FSM states, symbol codes,
// element limits and per-state unit counts.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MARK  = 3'd1,
    SPACE = 3'd2,
    GAP   = 3'd3,
    WORD  = 3'd4
  } state_t;

  localparam logic [5:0] CODE_SPACE      = 6'd36;
  localparam logic [5:0] CODE_LAST_VALID = 6'd36;
  localparam int         MAX_ELEMS       = 5;

  localparam logic [2:0] DOT_UNITS   = 3'd1;
  localparam logic [2:0] DASH_UNITS  = 3'd3;
  localparam logic [2:0] SPACE_UNITS = 3'd1;
  localparam logic [2:0] GAP_UNITS   = 3'd3;
  localparam logic [2:0] WORD_UNITS  = 3'd4;

endpackage

// File: rtl/morse_rom.sv
// Combinational code -> {element count, pattern} table. Patterns are left-aligned
// so the first element sits in bit 4 (1 = dash); unused and invalid codes give zero.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] code,
  output logic [2:0] len,
  output logic [MAX_ELEMS-1:0] pattern
);

  always_comb begin
    len     = 3'd0;
    pattern = 5'b00000;
    case (code)
      6'd0:  begin len = 3'd2; pattern = 5'b01000; end  // A .-
      6'd1:  begin len = 3'd4; pattern = 5'b10000; end  // B -...
      6'd2:  begin len = 3'd4; pattern = 5'b10100; end  // C -.-.
      6'd3:  begin len = 3'd3; pattern = 5'b10000; end  // D -..
      6'd4:  begin len = 3'd1; pattern = 5'b00000; end  // E .
      6'd5:  begin len = 3'd4; pattern = 5'b00100; end  // F ..-.
      6'd6:  begin len = 3'd3; pattern = 5'b11000; end  // G --.
      6'd7:  begin len = 3'd4; pattern = 5'b00000; end  // H ....
      6'd8:  begin len = 3'd2; pattern = 5'b00000; end  // I ..
      6'd9:  begin len = 3'd4; pattern = 5'b01110; end  // J .---
      6'd10: begin len = 3'd3; pattern = 5'b10100; end  // K -.-
      6'd11: begin len = 3'd4; pattern = 5'b01000; end  // L .-..
      6'd12: begin len = 3'd2; pattern = 5'b11000; end  // M --
      6'd13: begin len = 3'd2; pattern = 5'b10000; end  // N -.
      6'd14: begin len = 3'd3; pattern = 5'b11100; end  // O ---
      6'd15: begin len = 3'd4; pattern = 5'b01100; end  // P .--.
      6'd16: begin len = 3'd4; pattern = 5'b11010; end  // Q --.-
      6'd17: begin len = 3'd3; pattern = 5'b01000; end  // R .-.
      6'd18: begin len = 3'd3; pattern = 5'b00000; end  // S ...
      6'd19: begin len = 3'd1; pattern = 5'b10000; end  // T -
      6'd20: begin len = 3'd3; pattern = 5'b00100; end  // U ..-
      6'd21: begin len = 3'd4; pattern = 5'b00010; end  // V ...-
      6'd22: begin len = 3'd3; pattern = 5'b01100; end  // W .--
      6'd23: begin len = 3'd4; pattern = 5'b10010; end  // X -..-
      6'd24: begin len = 3'd4; pattern = 5'b10110; end  // Y -.--
      6'd25: begin len = 3'd4; pattern = 5'b11000; end  // Z --..
      6'd26: begin len = 3'd5; pattern = 5'b11111; end  // 0
      6'd27: begin len = 3'd5; pattern = 5'b01111; end  // 1
      6'd28: begin len = 3'd5; pattern = 5'b00111; end  // 2
      6'd29: begin len = 3'd5; pattern = 5'b00011; end  // 3
      6'd30: begin len = 3'd5; pattern = 5'b00001; end  // 4
      6'd31: begin len = 3'd5; pattern = 5'b00000; end  // 5
      6'd32: begin len = 3'd5; pattern = 5'b10000; end  // 6
      6'd33: begin len = 3'd5; pattern = 5'b11000; end  // 7
      6'd34: begin len = 3'd5; pattern = 5'b11100; end  // 8
      6'd35: begin len = 3'd5; pattern = 5'b11110; end  // 9
      default: begin len = 3'd0; pattern = 5'b00000; end
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// Morse keyer: accepts one symbol code when idle and keys it out with dot/dash/gap
// timing in units of L cycles, L latched from unit_div/UNIT_COUNT at acceptance.
module morse_encoder
  import morse_pkg::*;
#(
  parameter logic [23:0] UNIT_COUNT = 24'd1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [7:0] unit_div,
  output logic       key_out,
  output logic       busy,
  output logic       char_done
);

  state_t               state, state_nxt;
  logic [23:0]          pre_cnt, unit_len;
  logic [2:0]           unit_cnt, elem_left, state_units, rom_len;
  logic [MAX_ELEMS-1:0] pattern, rom_pat;
  logic                 accept, load, tick, state_end;

  morse_rom u_rom (
    .code    (char_in),
    .len     (rom_len),
    .pattern (rom_pat)
  );

  assign accept    = char_valid && (state == IDLE);
  assign load      = accept && (char_in <= CODE_LAST_VALID);
  assign tick      = (pre_cnt == unit_len - 24'd1);
  assign state_end = tick && (unit_cnt == state_units - 3'd1);

  assign char_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign key_out    = (state == MARK);

  always_comb begin
    state_units = 3'd1;
    case (state)
      MARK:    state_units = pattern[MAX_ELEMS-1] ? DASH_UNITS : DOT_UNITS;
      SPACE:   state_units = SPACE_UNITS;
      GAP:     state_units = GAP_UNITS;
      WORD:    state_units = WORD_UNITS;
      default: state_units = 3'd1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    char_done = 1'b0;
    case (state)
      IDLE: begin
        // Invalid codes are accepted (ready is high) but simply leave us in IDLE.
        if (load) state_nxt = (char_in == CODE_SPACE) ? WORD : MARK;
      end
      MARK:  if (state_end) state_nxt = (elem_left == 3'd1) ? GAP : SPACE;
      SPACE: if (state_end) state_nxt = MARK;
      GAP, WORD: begin
        if (state_end) begin
          state_nxt = IDLE;
          char_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset || (state_nxt != state)) begin
      pre_cnt  <= 24'd0;
      unit_cnt <= 3'd0;
    end else if (state != IDLE) begin
      if (tick) begin
        pre_cnt  <= 24'd0;
        unit_cnt <= unit_cnt + 3'd1;
      end else begin
        pre_cnt  <= pre_cnt + 24'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      unit_len  <= 24'd0;
      pattern   <= '0;
      elem_left <= 3'd0;
    end else if (load) begin
      unit_len  <= (unit_div == 8'd0) ? UNIT_COUNT : {6'b0, unit_div, 10'b0};
      pattern   <= rom_pat;
      elem_left <= rom_len;
    end else if ((state == MARK) && state_end) begin
      pattern   <= pattern << 1;
      elem_left <= elem_left - 3'd1;
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_COUNT=4: captures outputs per cycle
// after acceptance and compares against hand-derived waveforms.
module tb_morse_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] unit_div;
  logic       key_out;
  logic       busy;
  logic       char_done;

  int n_checks = 0;
  int n_errors = 0;

  logic key_a  [0:4199];
  logic busy_a [0:4199];
  logic done_a [0:4199];
  logic rdy_a  [0:4199];

  morse_encoder #(.UNIT_COUNT(24'd4)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .unit_div   (unit_div),
    .key_out    (key_out),
    .busy       (busy),
    .char_done  (char_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for ready, then presents one code for a single accepting edge.
  task automatic send(input logic [5:0] code, input logic [7:0] div);
    int w = 0;
    @(negedge clk);
    while (!char_ready && w < 6000) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_send", char_ready, 1);
    char_in    = code;
    char_valid = 1'b1;
    unit_div   = div;
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  // Samples cycles 1..n after acceptance; optional reset, unit_div change, busy-time valid.
  task automatic capture(input int n, input int rst_at, input int div_at, input int glitch_at);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      key_a[k]  = key_out;
      busy_a[k] = busy;
      done_a[k] = char_done;
      rdy_a[k]  = char_ready;
      reset = (k == rst_at);
      if (k == div_at) unit_div = 8'd0;
      if (k == glitch_at) begin
        char_in    = 6'd36;
        char_valid = 1'b1;
      end else begin
        char_valid = 1'b0;
      end
    end
  endtask

  task automatic chk_key(input string tag, input int lo, input int hi, input logic v);
    for (int i = lo; i <= hi; i++) check($sformatf("%s_key_c%0d", tag, i), key_a[i], v);
  endtask

  task automatic chk_done(input string tag, input int n, input int at);
    for (int i = 1; i <= n; i++)
      check($sformatf("%s_done_c%0d", tag, i), done_a[i], (i == at) ? 1 : 0);
  endtask

  initial begin
    reset      = 1'b1;
    char_in    = 6'd0;
    char_valid = 1'b0;
    unit_div   = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", char_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_key", key_out, 0);
    check("rst_done", char_done, 0);
    reset = 1'b0;

    // E: one dot, 3-unit gap
    send(6'd4, 8'd0);
    capture(17, 0, 0, 0);
    chk_key("E", 1, 4, 1);
    chk_key("E", 5, 16, 0);
    chk_done("E", 17, 16);
    check("E_busy_c1", busy_a[1], 1);
    check("E_ready_c16", rdy_a[16], 0);
    check("E_ready_c17", rdy_a[17], 1);

    // A: dot, space, dash, gap; a valid pulse while busy must be ignored
    send(6'd0, 8'd0);
    capture(40, 0, 0, 3);
    chk_key("A", 1, 4, 1);
    chk_key("A", 5, 8, 0);
    chk_key("A", 9, 20, 1);
    chk_key("A", 21, 40, 0);
    chk_done("A", 40, 32);
    check("A_ready_c32", rdy_a[32], 0);
    check("A_ready_c33", rdy_a[33], 1);
    check("A_busy_c40", busy_a[40], 0);

    // Digit 0: five dashes
    send(6'd26, 8'd0);
    capture(89, 0, 0, 0);
    for (int e = 0; e < 5; e++) begin
      chk_key("D0m", 1 + 16*e, 12 + 16*e, 1);
      if (e < 4) chk_key("D0s", 13 + 16*e, 16 + 16*e, 0);
    end
    chk_key("D0g", 77, 88, 0);
    chk_done("D0", 89, 88);
    check("D0_ready_c89", rdy_a[89], 1);

    // Word space
    send(6'd36, 8'd0);
    capture(17, 0, 0, 0);
    chk_key("W", 1, 16, 0);
    for (int i = 1; i <= 16; i++) check($sformatf("W_busy_c%0d", i), busy_a[i], 1);
    chk_done("W", 17, 16);
    check("W_ready_c17", rdy_a[17], 1);

    // Invalid code is consumed without effect
    send(6'd40, 8'd0);
    capture(10, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      check($sformatf("INV_ready_c%0d", i), rdy_a[i], 1);
      check($sformatf("INV_busy_c%0d", i), busy_a[i], 0);
    end
    chk_done("INV", 10, 0);

    // unit_div=1 -> L=1024, changed to 0 mid-symbol
    send(6'd4, 8'd1);
    capture(4097, 0, 10, 0);
    chk_key("DIV", 1, 1024, 1);
    chk_key("DIV", 1025, 1030, 0);
    chk_key("DIV", 4090, 4096, 0);
    chk_done("DIV", 4097, 4096);
    check("DIV_ready_c4097", rdy_a[4097], 1);

    // Reset mid-symbol aborts A
    send(6'd0, 8'd0);
    capture(40, 6, 0, 0);
    chk_key("RST", 1, 4, 1);
    chk_key("RST", 5, 40, 0);
    for (int i = 7; i <= 40; i++) begin
      check($sformatf("RST_busy_c%0d", i), busy_a[i], 0);
      check($sformatf("RST_ready_c%0d", i), rdy_a[i], 1);
    end
    chk_done("RST", 40, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/morse_encoder.md
MORSE_ENCODER -- requirements
Module: morse_encoder

Interface
REQ-001 Parameter UNIT_COUNT, default 24'd1_000_000, sets the default Morse unit length in clk cycles (100 ms at 10 MHz); legal values are 1 and above.
REQ-002 clk  input  1  system clock, 10 MHz nominal.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 char_in  input  6  symbol code: 0-25 = A-Z, 26-35 = digits 0-9, 36 = word space, 37-63 = invalid.
REQ-005 char_valid  input  1  char_in is valid; a transfer occurs when char_valid and char_ready are both high on a rising clk edge.
REQ-006 char_ready  output  1  block is idle and can accept a symbol.
REQ-007 unit_div  input  8  unit-length override: 0 selects UNIT_COUNT; any other value selects {6'b0, unit_div, 10'b0}.
REQ-008 key_out  output  1  Morse keying output, 1 = tone/mark.
REQ-009 busy  output  1  high while a symbol is being sent.
REQ-010 char_done  output  1  one-cycle pulse when a symbol (including word space) finishes.

Function
REQ-011 Let L be the unit length in cycles, selected per REQ-007; L SHALL be sampled only on an accepted transfer and held for the whole symbol.
REQ-012 The block SHALL implement the FSM states IDLE, MARK, SPACE, GAP and WORD.
REQ-013 In IDLE: char_ready=1, busy=0, key_out=0.
REQ-014 IDLE on an accepted valid code 0-35: load the element pattern and length, then go to MARK for the first element.
REQ-015 IDLE on accepted code 36: go to WORD.
REQ-016 IDLE on accepted code 37-63: the code SHALL be consumed and dropped, with the FSM remaining in IDLE and no char_done.
REQ-017 MARK: key_out=1 for exactly L cycles (dot) or 3L cycles (dash), starting the cycle after acceptance or after the preceding SPACE.
REQ-018 After a non-final element, go to SPACE: key_out=0 for exactly L cycles, then MARK for the next element.
REQ-019 After the final element, go to GAP: key_out=0 for exactly 3L cycles.
REQ-020 WORD: key_out=0 for exactly 4L cycles; together with the preceding GAP this gives a 7-unit word gap.
REQ-021 At the end of GAP or WORD, char_done=1 for one cycle and the FSM returns to IDLE; char_ready=1 in the following cycle.
REQ-022 Timing SHALL use a 24-bit prescaler counting 0..L-1 that emits a unit tick at L-1 and wraps.
REQ-023 A 3-bit unit counter SHALL count units within each state.
REQ-024 Both counters SHALL be cleared on every state entry.
REQ-025 Elements SHALL be sent MSB-first from a 5-bit pattern (1 = dash) with a 3-bit length of 1..5, following International Morse code.
REQ-026 busy SHALL be 1 in MARK, SPACE, GAP and WORD.
REQ-027 char_valid while not ready SHALL be ignored, and char_in is not captured.
REQ-028 Changing unit_div mid-symbol SHALL NOT affect the current symbol.

Reset
REQ-029 reset SHALL force, in the next cycle: FSM=IDLE, both counters=0, key_out=0, busy=0, char_done=0, char_ready=1, stored pattern/length=0.
REQ-030 reset mid-symbol SHALL abort the symbol immediately, with no char_done.

Structure
REQ-031 Shared package morse_pkg SHALL hold the FSM state typedef, symbol code constants (CODE_SPACE=36, CODE_LAST_VALID=36), and the MAX_ELEMS=5 and gap-unit constants (1, 3, 4).
REQ-032 The code-to-{length, pattern} table SHALL be a combinational sub-module named morse_rom.

Verification (UNIT_COUNT=4, unit_div=0, acceptance at cycle 0)
REQ-033 'E' (code 4): key_out=1 in cycles 1-4 and 0 in cycles 5-16; char_done at cycle 16; char_ready=1 at cycle 17.
REQ-034 'A' (code 0): key_out=1 in cycles 1-4, 0 in 5-8, 1 in 9-20, and 0 in 21-32; char_ready at cycle 33.
REQ-035 Digit '0' (code 26): 5 marks of 12 cycles each separated by 4-cycle spaces, then 12 low cycles; char_done at cycle 88.
REQ-036 Word space (code 36): key_out=0 with busy=1 in cycles 1-16, char_done at 16; invalid code 40 leaves char_ready=1 and busy=0 with no char_done.
REQ-037 unit_div=1 with 'E': mark is 1024 cycles; toggling unit_div to 0 at cycle 10 does not change the mark length.
REQ-038 reset asserted at cycle 6 of 'A': key_out=0, busy=0 and char_ready=1 from cycle 7, with no char_done.
